mem_wb_stage: RTL and testbench

Memory stage plus M/WB pipeline latch of the pipelined MIPS core. It consumes the EX/M latch outputs and drives the data-cache request. It stalls the pipeline while a load or store is outstanding, captures load data on `dhit`, and registers everything the write-back stage needs. It sits between the EX/M latch and the register-file write port / hazard unit.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/MEM_WB_if.sv | 7 +
 rtl/mw_latch.sv | 15 +
 rtl/mem_wb_stage.sv | 88 ++++++++
 tb/tb_mem_wb_stage.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared widths, opcode encodings, memory-stage state and M/WB record.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    localparam int REGSEL_W = 5;
    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] SLL = 6'b000000;
    typedef enum logic [1:0] {IDLE, REQ, DONE} memstate_t;
    typedef struct packed {
        logic [WORD_W-1:0] dmemload;
        logic [WORD_W-1:0] porto;
        logic [WORD_W-1:0] pcp4;
        logic memtoreg;
        logic [1:0] wdatasrc;
        logic [REGSEL_W-1:0] wsel;
        logic wen;
        logic halt;
        logic [5:0] opcode;
        logic [5:0] funct;
    } mw_t;
    function automatic mw_t bubble();
        mw_t b;
        b = '0;
        b.opcode = RTYPE;
        b.funct = SLL;
        return b;
    endfunction
endpackage

// File: rtl/MEM_WB_if.sv
// MEM_WB_if: M/WB bundle, next value in d and latched value in q.
interface MEM_WB_if;
    import cpu_types_pkg::*;
    mw_t d;
    mw_t q;
    modport latch (input d, output q);
endinterface

// File: rtl/mw_latch.sv
// mw_latch: M/WB pipeline register with async reset, flush-to-bubble and enable.
module mw_latch
    import cpu_types_pkg::*;
(
    input logic CLK,
    input logic RST,
    input logic flush,
    input logic en,
    MEM_WB_if.latch bus
);
    always_ff @(posedge CLK or posedge RST)
        if (RST) bus.q <= bubble();
        else if (flush) bus.q <= bubble();
        else if (en) bus.q <= bus.d;
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-cache access FSM, stall generation and M/WB latch.
module mem_wb_stage
    import cpu_types_pkg::*;
#(
    parameter int WCNT_W = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic ihit,
    input  logic flush,
    input  logic dREN_in,
    input  logic dWEN_in,
    input  logic [WORD_W-1:0] portO_in,
    input  logic [WORD_W-1:0] dmemStore_in,
    input  logic MemtoReg_in,
    input  logic [1:0] wdatasrc_in,
    input  logic [REGSEL_W-1:0] WSel_in,
    input  logic WEN_in,
    input  logic [WORD_W-1:0] pcp4_in,
    input  logic HALT_in,
    input  logic [5:0] opcode_in,
    input  logic [5:0] funct_in,
    input  logic dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic dmemREN,
    output logic dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic mem_stall,
    output logic advance,
    output logic [WORD_W-1:0] dmemload_out,
    output logic [WORD_W-1:0] portO_out,
    output logic [WORD_W-1:0] pcp4_out,
    output logic MemtoReg_out,
    output logic [1:0] wdatasrc_out,
    output logic [REGSEL_W-1:0] WSel_out,
    output logic WEN_out,
    output logic HALT_out,
    output logic [5:0] opcode_out,
    output logic [5:0] funct_out,
    output logic halted,
    output logic [WCNT_W-1:0] memwait_cnt
);
    memstate_t state, next;
    logic req;
    logic [WORD_W-1:0] hold;
    MEM_WB_if mw ();
    assign req = dREN_in | dWEN_in;
    assign mem_stall = req & ~dhit & (state != DONE);
    assign advance = ihit & ~mem_stall;
    // Strobes drop combinationally on RST so they fall without waiting for an edge.
    assign dmemREN = dREN_in & (state != DONE) & ~halted & ~RST;
    assign dmemWEN = dWEN_in & ~dREN_in & (state != DONE) & ~halted & ~RST;
    assign dmemaddr = portO_in;
    assign dmemstore = dmemStore_in;
    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= IDLE;
        else state <= next;
    // Completion that advances in the same cycle skips DONE so the next access can issue.
    always_comb begin
        next = (flush | advance) ? IDLE :
               (req & dhit) ? DONE :
               (req & (state == IDLE)) ? REQ : state;
    end
    always_ff @(posedge CLK or posedge RST)
        if (RST) hold <= '0;
        else if (dhit & dREN_in) hold <= dmemload;
    always_ff @(posedge CLK or posedge RST)
        if (RST) halted <= 1'b0;
        else if (~flush & advance & HALT_in) halted <= 1'b1;
    always_ff @(posedge CLK or posedge RST)
        if (RST) memwait_cnt <= '0;
        else if (mem_stall & ~&memwait_cnt) memwait_cnt <= memwait_cnt + 1'b1;
    assign mw.d = '{dmemload: dhit ? dmemload : hold, porto: portO_in, pcp4: pcp4_in,
                    memtoreg: MemtoReg_in, wdatasrc: wdatasrc_in, wsel: WSel_in, wen: WEN_in,
                    halt: HALT_in, opcode: opcode_in, funct: funct_in};
    mw_latch u_latch (.CLK(CLK), .RST(RST), .flush(flush), .en(advance), .bus(mw));
    assign dmemload_out = mw.q.dmemload;
    assign portO_out = mw.q.porto;
    assign pcp4_out = mw.q.pcp4;
    assign MemtoReg_out = mw.q.memtoreg;
    assign wdatasrc_out = mw.q.wdatasrc;
    assign WSel_out = mw.q.wsel;
    assign WEN_out = mw.q.wen;
    assign HALT_out = mw.q.halt;
    assign opcode_out = mw.q.opcode;
    assign funct_out = mw.q.funct;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vector table plus hand sequences for stalls, flush, halt and reset.
module tb_mem_wb_stage;
    logic CLK, RST, ihit, flush, dREN_in, dWEN_in, MemtoReg_in, WEN_in, HALT_in, dhit;
    logic [31:0] portO_in, dmemStore_in, pcp4_in, dmemload;
    logic [1:0] wdatasrc_in;
    logic [4:0] WSel_in;
    logic [5:0] opcode_in, funct_in;
    logic dmemREN, dmemWEN, mem_stall, advance, MemtoReg_out, WEN_out, HALT_out, halted;
    logic [31:0] dmemaddr, dmemstore, dmemload_out, portO_out, pcp4_out;
    logic [1:0] wdatasrc_out;
    logic [4:0] WSel_out;
    logic [5:0] opcode_out, funct_out;
    logic [7:0] memwait_cnt;
    int n_cmp = 0;
    int n_err = 0;

    mem_wb_stage #(.WCNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .flush(flush), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
        .portO_in(portO_in), .dmemStore_in(dmemStore_in), .MemtoReg_in(MemtoReg_in),
        .wdatasrc_in(wdatasrc_in), .WSel_in(WSel_in), .WEN_in(WEN_in), .pcp4_in(pcp4_in),
        .HALT_in(HALT_in), .opcode_in(opcode_in), .funct_in(funct_in), .dhit(dhit),
        .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_stall(mem_stall), .advance(advance),
        .dmemload_out(dmemload_out), .portO_out(portO_out), .pcp4_out(pcp4_out),
        .MemtoReg_out(MemtoReg_out), .wdatasrc_out(wdatasrc_out), .WSel_out(WSel_out),
        .WEN_out(WEN_out), .HALT_out(HALT_out), .opcode_out(opcode_out), .funct_out(funct_out),
        .halted(halted), .memwait_cnt(memwait_cnt)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic ihit, flush;
        logic [31:0] porto;
        logic [4:0] wsel;
        logic [5:0] op;
        logic [31:0] e_porto;
        logic [4:0] e_wsel;
        logic [5:0] e_op;
    } vec_t;
    vec_t v[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int stalls, wen_cycles;
        v[0] = '{1'b1, 1'b0, 32'h0000_00A4, 5'd5, 6'h08, 32'h0000_00A4, 5'd5, 6'h08};
        v[1] = '{1'b0, 1'b0, 32'h0000_0055, 5'd7, 6'h0D, 32'h0000_00A4, 5'd5, 6'h08};
        v[2] = '{1'b1, 1'b0, 32'h0000_0055, 5'd7, 6'h0D, 32'h0000_0055, 5'd7, 6'h0D};
        v[3] = '{1'b1, 1'b1, 32'h0000_0099, 5'd9, 6'h0F, 32'h0000_0000, 5'd0, 6'h00};
        v[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 5'd31, 6'h3F, 32'hFFFF_FFFF, 5'd31, 6'h3F};
        v[5] = '{1'b0, 1'b1, 32'h1234_5678, 5'd1, 6'h01, 32'h0000_0000, 5'd0, 6'h00};
        RST = 1; ihit = 0; flush = 0; dREN_in = 1; dWEN_in = 0; MemtoReg_in = 0; WEN_in = 1;
        HALT_in = 0; dhit = 0; portO_in = 32'h40; dmemStore_in = 0; pcp4_in = 32'h44;
        dmemload = 0; wdatasrc_in = 2'd1; WSel_in = 5'd2; opcode_in = 6'h08; funct_in = 6'h20;
        #2;
        chk("rst_ren", dmemREN, 0);
        chk("rst_porto", portO_out, 0);
        chk("rst_opcode", opcode_out, 6'h00);
        chk("rst_funct", funct_out, 6'h00);
        chk("rst_wen", WEN_out, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cnt", memwait_cnt, 0);
        dREN_in = 0;
        @(negedge CLK);
        RST = 0;
        for (int i = 0; i < 6; i++) begin
            ihit = v[i].ihit; flush = v[i].flush; portO_in = v[i].porto;
            WSel_in = v[i].wsel; opcode_in = v[i].op;
            #1;
            chk($sformatf("vec%0d_stall", i), mem_stall, 0);
            tick();
            chk($sformatf("vec%0d_porto", i), portO_out, v[i].e_porto);
            chk($sformatf("vec%0d_wsel", i), WSel_out, v[i].e_wsel);
            chk($sformatf("vec%0d_op", i), opcode_out, v[i].e_op);
        end
        flush = 0; ihit = 1; dREN_in = 1; portO_in = 32'h100; MemtoReg_in = 1; WSel_in = 5'd3;
        opcode_in = 6'h23; dhit = 0;
        #1;
        chk("ld_ren", dmemREN, 1);
        chk("ld_addr", dmemaddr, 32'h100);
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_stall) stalls++;
            tick();
        end
        dhit = 1; dmemload = 32'hDEAD_BEEF;
        #1;
        chk("ld_hit_stall", mem_stall, 0);
        chk("ld_hit_adv", advance, 1);
        tick();
        dREN_in = 0; dhit = 0; dmemload = 0;
        chk("ld_stalls", stalls, 3);
        chk("ld_data", dmemload_out, 32'hDEAD_BEEF);
        chk("ld_wsel", WSel_out, 5'd3);
        chk("ld_memtoreg", MemtoReg_out, 1);
        chk("ld_cnt", memwait_cnt, 3);
        dWEN_in = 1; dmemStore_in = 32'h1234_5678; portO_in = 32'h200; MemtoReg_in = 0;
        opcode_in = 6'h2B; ihit = 0; dhit = 1;
        wen_cycles = 0;
        #1;
        if (dmemWEN) wen_cycles++;
        chk("st_store", dmemstore, 32'h1234_5678);
        chk("st_stall", mem_stall, 0);
        tick();
        dhit = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (dmemWEN) wen_cycles++;
            chk($sformatf("st_hold%0d_adv", i), advance, 0);
            chk($sformatf("st_hold%0d_stall", i), mem_stall, 0);
            tick();
        end
        chk("st_held_porto", portO_out, 32'h100);
        ihit = 1;
        #1;
        if (dmemWEN) wen_cycles++;
        chk("st_adv", advance, 1);
        tick();
        dWEN_in = 0;
        chk("st_wen_cycles", wen_cycles, 1);
        chk("st_porto", portO_out, 32'h200);
        chk("st_cnt", memwait_cnt, 3);
        dREN_in = 1; portO_in = 32'h300; opcode_in = 6'h23; MemtoReg_in = 1;
        tick();
        dhit = 1; flush = 1; dmemload = 32'hCAFE_F00D;
        tick();
        flush = 0; dhit = 0; dREN_in = 0;
        #1;
        chk("fl_ren", dmemREN, 0);
        chk("fl_porto", portO_out, 0);
        chk("fl_data", dmemload_out, 0);
        chk("fl_opcode", opcode_out, 6'h00);
        chk("fl_memtoreg", MemtoReg_out, 0);
        dREN_in = 1; portO_in = 32'h310;
        #1;
        chk("fl_idle_ren", dmemREN, 1);
        dhit = 1; dmemload = 32'h1111_2222;
        #1;
        chk("fl_hit_stall", mem_stall, 0);
        tick();
        dREN_in = 0; dhit = 0;
        chk("fl_next_data", dmemload_out, 32'h1111_2222);
        chk("fl_cnt", memwait_cnt, 4);
        HALT_in = 1; portO_in = 32'h400; opcode_in = 6'h3F; MemtoReg_in = 0;
        tick();
        HALT_in = 0;
        chk("halt_flag", halted, 1);
        chk("halt_out", HALT_out, 1);
        dREN_in = 1; portO_in = 32'h500;
        #1;
        chk("halt_ren", dmemREN, 0);
        tick();
        chk("halt_sticky", halted, 1);
        #2;
        RST = 1;
        #1;
        chk("arst_ren", dmemREN, 0);
        chk("arst_halted", halted, 0);
        chk("arst_halt_out", HALT_out, 0);
        chk("arst_cnt", memwait_cnt, 0);
        @(negedge CLK);
        RST = 0;
        #1;
        chk("arst_rel_ren", dmemREN, 1);
        tick();
        chk("req_stall", mem_stall, 1);
        #2;
        RST = 1;
        #1;
        chk("mid_rst_ren", dmemREN, 0);
        chk("mid_rst_cnt", memwait_cnt, 0);
        @(negedge CLK);
        RST = 0;
        #1;
        chk("mid_rel_ren", dmemREN, 1);
        repeat (260) tick();
        chk("sat_cnt", memwait_cnt, 8'hFF);
        chk("sat_stall", mem_stall, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
